sseg_scan_ctrl: RTL and testbench
=================================

Name: sseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an NUM_DIGITS-digit common-anode seven-segment display.
- Shares one BCDtoSevenSegment decoder instance across all digits.
- Owns a double-buffered digit register with a load handshake; updates are applied only at frame boundaries, so the display never tears.
- Sits between the datapath that produces BCD values and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 2..8.
- DWELL_CYCLES, 50000: clocks each digit is driven per visit; must be >= 1.
- GAP_CYCLES, 2: anti-ghosting blank clocks between digits; 0 removes the gap.

Ports:
- clock  input  1  system clock; all state is updated on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scan; 0 = display dark.
- load_req  input  1  request to load load_bcd into staging.
- load_bcd  input  4*NUM_DIGITS  nibble k is digit k; digit 0 is least significant.
- load_ready  output  1  staging register free.
- load_ack  output  1  one-cycle pulse when staged data becomes visible.
- digit_sel  output  NUM_DIGITS  active-low one-hot anode select.
- segment  output  7  active-low segments {g,f,e,d,c,b,a}.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (asynchronous, any state):
  - state=OFF, idx=0, counter=0.
  - display=0, staging=0, pending=0.
  - digit_sel=all 1s, segment=7'h7F.
  - load_ack=0, frame_done=0.
- Outputs:
  - segment, digit_sel, load_ack and frame_done are registered.
  - segment and digit_sel always change on the same edge.
- States: OFF, DRIVE, GAP.
- OFF:
  - Pins dark.
  - enable=1 -> DRIVE with idx=0, counter=0.
- DRIVE:
  - digit_sel[idx]=0; segment = decode(display[idx]).
  - After DWELL_CYCLES clocks, go to GAP, or directly to the next digit when GAP_CYCLES=0.
- GAP:
  - Pins dark for GAP_CYCLES clocks, then idx advances.
- Index wrap:
  - idx advances to idx+1.
  - When idx=NUM_DIGITS-1 it wraps to 0; this is the frame boundary.
- Frame boundary:
  - frame_done pulses.
  - If pending, display<=staging, pending<=0, and load_ack pulses on the same edge the new digit 0 is driven.
- enable=0 in any state:
  - Next edge -> OFF and pins dark.
  - idx and counter are cleared; display and pending are kept.
- Load handshake:
  - load_ready = !pending.
  - load_req && load_ready captures load_bcd into staging and sets pending.
  - A request while pending=1 is ignored; the requester must hold it.
- Loads while in OFF:
  - A pending load is applied on the first edge after acceptance, with a load_ack pulse.
  - Pins stay dark.
- Frame boundary coincident with load_req:
  - pending=1 in that cycle, so the request is not accepted.
  - It is accepted the following cycle at the earliest.
- Decoding:
  - Nibbles 4'hA..4'hF decode to 7'h7F (digit selected but dark).
  - Digit codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=18 (hex).
- Counter:
  - Width is $clog2(max(DWELL_CYCLES, GAP_CYCLES)+1).
  - Reloads to 0 on every state change.

Optional Feature:
- Macro: SSEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Digit k is dark (segment=7'h7F, anode still driven) when display[k]==0 and all higher digits are 0.
  - Digit 0 is never suppressed.
  - Suppression is computed from display, not staging.
- Undefined: every digit shows its decoded value, zeros included.

Decomposition:
- Package sseg_pkg:
  - SEG_BLANK=7'h7F.
  - scan_state_t enum {OFF, DRIVE, GAP}.
  - Digit code constants.
- Sub-modules:
  - One existing BCDtoSevenSegment instance, fed by the display[idx] mux.
  - One sub-module sseg_buffer: the staging/display double buffer and the load handshake.
- FSM, counter and pin registers live in the top module.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=4, GAP_CYCLES=1):
- Reset:
  - Stimulus: reset_L=0 asserted mid-DRIVE.
  - Response, same cycle (asynchronous): digit_sel=4'hF, segment=7'h7F, load_ready=1.
- Basic scan:
  - Stimulus: load 16'h1234 while OFF, then enable=1.
  - Response: load_ack pulse; 4 clocks of sel=4'hE with seg=7'h19; 1 dark clock; 4 clocks of sel=4'hD with seg=7'h30; then 7'h24, then 7'h79; frame_done after digit 3's gap.
- Mid-frame load:
  - Stimulus: load 16'h0009 while digit 1 is driven.
  - Response: load_ready=0 until the boundary; digits 2 and 3 still show 7'h24 and 7'h79; at the boundary load_ack=1 and digit 0 shows 7'h18.
- Non-BCD and back-pressure:
  - Stimulus: load 16'hA000, then a second load_req while pending.
  - Response: the second request is ignored; digit 3 is selected with seg=7'h7F.
- Enable drop:
  - Stimulus: enable=0 at the 2nd dwell clock of digit 2.
  - Response: dark on the next edge; re-enable restarts at digit 0 with a full 4-clock dwell.
- SSEG_LZ_BLANK_EN defined:
  - 16'h0042 -> digits 3 and 2 are dark, digit 1 shows 7'h19, digit 0 shows 7'h24.
  - 16'h0000 -> only digit 0 shows, with 7'h40.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and segment constants for the seven-segment scan controller.
`default_nettype none

package sseg_pkg;

    localparam logic [6:0] SEG_BLANK   = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h18;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } scan_state_t;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes stay dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_DIGIT_0;
            4'd1:    seg = SEG_DIGIT_1;
            4'd2:    seg = SEG_DIGIT_2;
            4'd3:    seg = SEG_DIGIT_3;
            4'd4:    seg = SEG_DIGIT_4;
            4'd5:    seg = SEG_DIGIT_5;
            4'd6:    seg = SEG_DIGIT_6;
            4'd7:    seg = SEG_DIGIT_7;
            4'd8:    seg = SEG_DIGIT_8;
            4'd9:    seg = SEG_DIGIT_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/BCDtoSevenSegment.sv
// Combinational BCD to active-low seven-segment decoder.
`default_nettype none

module BCDtoSevenSegment
    import sseg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] segment_o
);

    assign segment_o = bcd_to_seg(bcd_i);

endmodule

`default_nettype wire

// File: rtl/sseg_buffer.sv
// Staging/display double buffer with a ready/request load handshake.
`default_nettype none

module sseg_buffer #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_req_i,
    input  logic [4*NUM_DIGITS-1:0] load_bcd_i,
    input  logic                    apply_i,
    output logic                    load_ready_o,
    output logic                    applying_o,
    output logic [4*NUM_DIGITS-1:0] display_nxt_o
);

    logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
    logic [4*NUM_DIGITS-1:0] display_q, display_d;
    logic                    pending_q, pending_d;
    logic                    accept;

    assign accept       = load_req_i && !pending_q;
    assign applying_o   = apply_i && pending_q;
    assign load_ready_o = !pending_q;

    // accept and applying are exclusive: one needs pending clear, the other set.
    always_comb begin
        staging_d = accept ? load_bcd_i : staging_q;
        display_d = applying_o ? staging_q : display_q;
        pending_d = pending_q;
        if (accept) begin
            pending_d = 1'b1;
        end else if (applying_o) begin
            pending_d = 1'b0;
        end
    end

    assign display_nxt_o = display_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staging_q <= '0;
            display_q <= '0;
            pending_q <= 1'b0;
        end else begin
            staging_q <= staging_d;
            display_q <= display_d;
            pending_q <= pending_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scan controller with tear-free loads.
// Optional leading-zero blanking: define SSEG_LZ_BLANK_EN.
`default_nettype none

module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic                    enable,
    input  logic                    load_req,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    output logic                    load_ready,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [6:0]              segment,
    output logic                    frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_t             state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d, idx_inc;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic                    ack_q, fd_q;
    logic                    idx_last, wrap, apply_req, applying, blank;
    logic [4*NUM_DIGITS-1:0] disp_nxt;
    logic [3:0]              digits [NUM_DIGITS];
    logic [6:0]              dec_seg;

    assign apply_req = (state_q == OFF) || wrap;

    sseg_buffer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_buffer (
        .clk_i         (clock),
        .rst_ni        (reset_L),
        .load_req_i    (load_req),
        .load_bcd_i    (load_bcd),
        .apply_i       (apply_req),
        .load_ready_o  (load_ready),
        .applying_o    (applying),
        .display_nxt_o (disp_nxt)
    );

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign digits[k] = disp_nxt[4*k +: 4];
    end

    // Decode the digit that will be visible after this edge so pins stay registered.
    BCDtoSevenSegment u_dec (
        .bcd_i     (digits[idx_d]),
        .segment_o (dec_seg)
    );

`ifdef SSEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zeros_above = zeros_above && (digits[k] == 4'd0);
            lz[k]       = zeros_above;
        end
    end
    assign blank = (idx_d != '0) && lz[idx_d];
`else
    assign blank = 1'b0;
`endif

    assign idx_last = (idx_q == IDX_LAST);
    assign idx_inc  = idx_last ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CW'(1);
        wrap    = 1'b0;
        if (!enable) begin
            state_d = OFF;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                        end else begin
                            idx_d = idx_inc;
                            wrap  = idx_last;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        idx_d   = idx_inc;
                        wrap    = idx_last;
                    end
                end
                default: begin
                    state_d = OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign sel_d = (state_d == DRIVE) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
    assign seg_d = ((state_d == DRIVE) && !blank) ? dec_seg : SEG_BLANK;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '1;
            seg_q   <= SEG_BLANK;
            ack_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            ack_q   <= applying;
            fd_q    <= wrap;
        end
    end

    assign digit_sel  = sel_q;
    assign segment    = seg_q;
    assign load_ack   = ack_q;
    assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=4, GAP_CYCLES=1.
`default_nettype none

module tb_sseg_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        enable;
    logic        load_req;
    logic [15:0] load_bcd;
    logic        load_ready;
    logic        load_ack;
    logic [3:0]  digit_sel;
    logic [6:0]  segment;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SSEG_LZ_BLANK_EN
    localparam logic [6:0] LZ_SEG = 7'h7F;
`else
    localparam logic [6:0] LZ_SEG = 7'h40;
`endif

    always #5 clock = ~clock;

    sseg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DWELL_CYCLES (4),
        .GAP_CYCLES   (1)
    ) dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .enable     (enable),
        .load_req   (load_req),
        .load_bcd   (load_bcd),
        .load_ready (load_ready),
        .load_ack   (load_ack),
        .digit_sel  (digit_sel),
        .segment    (segment),
        .frame_done (frame_done)
    );

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0; enable = 1'b0; load_req = 1'b0; load_bcd = '0;
        run(2);
        vectors++;
        if (digit_sel !== 4'hF || segment !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_pins: sel=%h seg=%h want F/7f", digit_sel, segment);
        end
        vectors++;
        if (load_ready !== 1'b1 || load_ack !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: ready=%b ack=%b fd=%b want 1/0/0", load_ready, load_ack, frame_done);
        end
        reset_L = 1'b1;
        run(1);
        vectors++;
        if (digit_sel !== 4'hF || segment !== 7'h7F) begin
            miscompares++;
            $display("FAIL off_dark: sel=%h seg=%h want F/7f", digit_sel, segment);
        end
    endtask

    task automatic test_basic_scan();
        logic [6:0] exp_seg [4];
        exp_seg[0] = 7'h19; exp_seg[1] = 7'h30; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
        load_req = 1'b1; load_bcd = 16'h1234;
        run(1);
        load_req = 1'b0;
        vectors++;
        if (load_ready !== 1'b0 || load_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL off_accept: ready=%b ack=%b want 0/0", load_ready, load_ack);
        end
        run(1);
        vectors++;
        if (load_ack !== 1'b1 || load_ready !== 1'b1 || digit_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL off_apply: ack=%b ready=%b sel=%h want 1/1/F", load_ack, load_ready, digit_sel);
        end
        enable = 1'b1;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                run(1);
                vectors++;
                if (digit_sel !== ~(4'b0001 << d) || segment !== exp_seg[d] || frame_done !== 1'b0
                    || load_ack !== 1'b0) begin
                    miscompares++;
                    $display("FAIL scan_d%0d_c%0d: sel=%h seg=%h fd=%b ack=%b want %h/%h/0/0",
                             d, c, digit_sel, segment, frame_done, load_ack, ~(4'b0001 << d), exp_seg[d]);
                end
            end
            run(1);
            vectors++;
            if (digit_sel !== 4'hF || segment !== 7'h7F) begin
                miscompares++;
                $display("FAIL gap_d%0d: sel=%h seg=%h want F/7f", d, digit_sel, segment);
            end
        end
    endtask

    task automatic test_mid_frame_load();
        run(1);
        vectors++;
        if (frame_done !== 1'b1 || load_ack !== 1'b0 || digit_sel !== 4'hE || segment !== 7'h19) begin
            miscompares++;
            $display("FAIL boundary1: fd=%b ack=%b sel=%h seg=%h want 1/0/E/19", frame_done, load_ack, digit_sel, segment);
        end
        run(5);
        load_req = 1'b1; load_bcd = 16'h0009;
        run(1);
        load_req = 1'b0;
        vectors++;
        if (load_ready !== 1'b0 || digit_sel !== 4'hD) begin
            miscompares++;
            $display("FAIL mid_accept: ready=%b sel=%h want 0/D", load_ready, digit_sel);
        end
        run(4);
        for (int d = 2; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if (digit_sel !== ~(4'b0001 << d) || segment !== ((d == 2) ? 7'h24 : 7'h79) || load_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mid_hold_d%0d_c%0d: sel=%h seg=%h ready=%b", d, c, digit_sel, segment, load_ready);
                end
                run(1);
            end
            run(1);
        end
        vectors++;
        if (load_ack !== 1'b1 || frame_done !== 1'b1 || digit_sel !== 4'hE || segment !== 7'h18 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_apply: ack=%b fd=%b sel=%h seg=%h ready=%b want 1/1/E/18/1",
                     load_ack, frame_done, digit_sel, segment, load_ready);
        end
    endtask

    task automatic test_nonbcd_backpressure();
        load_req = 1'b1; load_bcd = 16'hA000;
        run(1);
        vectors++;
        if (load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept: ready=%b want 0", load_ready);
        end
        load_bcd = 16'h5555;
        run(1);
        load_req = 1'b0;
        vectors++;
        if (load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_pending: ready=%b want 0", load_ready);
        end
        run(18);
        vectors++;
        if (load_ack !== 1'b1 || digit_sel !== 4'hE || segment !== 7'h40) begin
            miscompares++;
            $display("FAIL bp_apply: ack=%b sel=%h seg=%h want 1/E/40", load_ack, digit_sel, segment);
        end
        run(5);
        vectors++;
        if (digit_sel !== 4'hD || segment !== 7'h40) begin
            miscompares++;
            $display("FAIL bp_ignored: sel=%h seg=%h want D/40", digit_sel, segment);
        end
        run(10);
        vectors++;
        if (digit_sel !== 4'h7 || segment !== 7'h7F) begin
            miscompares++;
            $display("FAIL nonbcd: sel=%h seg=%h want 7/7f", digit_sel, segment);
        end
    endtask

    task automatic test_enable_drop();
        run(16);
        vectors++;
        if (digit_sel !== 4'hB) begin
            miscompares++;
            $display("FAIL drop_pos: sel=%h want B", digit_sel);
        end
        enable = 1'b0;
        run(1);
        vectors++;
        if (digit_sel !== 4'hF || segment !== 7'h7F) begin
            miscompares++;
            $display("FAIL drop_dark: sel=%h seg=%h want F/7f", digit_sel, segment);
        end
        run(2);
        vectors++;
        if (digit_sel !== 4'hF || segment !== 7'h7F || load_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_hold: sel=%h seg=%h ack=%b want F/7f/0", digit_sel, segment, load_ack);
        end
        enable = 1'b1;
        run(1);
        vectors++;
        if (digit_sel !== 4'hE || segment !== 7'h40 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: sel=%h seg=%h fd=%b want E/40/0", digit_sel, segment, frame_done);
        end
        for (int c = 1; c < 4; c++) begin
            run(1);
            vectors++;
            if (digit_sel !== 4'hE) begin
                miscompares++;
                $display("FAIL restart_dwell_c%0d: sel=%h want E", c, digit_sel);
            end
        end
        run(1);
        vectors++;
        if (digit_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL restart_gap: sel=%h want F", digit_sel);
        end
    endtask

    task automatic test_leading_zero();
        load_req = 1'b1; load_bcd = 16'h0042;
        run(1);
        load_req = 1'b0;
        run(15);
        vectors++;
        if (load_ack !== 1'b1 || digit_sel !== 4'hE || segment !== 7'h24) begin
            miscompares++;
            $display("FAIL lz42_d0: ack=%b sel=%h seg=%h want 1/E/24", load_ack, digit_sel, segment);
        end
        run(5);
        vectors++;
        if (digit_sel !== 4'hD || segment !== 7'h19) begin
            miscompares++;
            $display("FAIL lz42_d1: sel=%h seg=%h want D/19", digit_sel, segment);
        end
        run(5);
        vectors++;
        if (digit_sel !== 4'hB || segment !== LZ_SEG) begin
            miscompares++;
            $display("FAIL lz42_d2: sel=%h seg=%h want B/%h", digit_sel, segment, LZ_SEG);
        end
        run(5);
        vectors++;
        if (digit_sel !== 4'h7 || segment !== LZ_SEG) begin
            miscompares++;
            $display("FAIL lz42_d3: sel=%h seg=%h want 7/%h", digit_sel, segment, LZ_SEG);
        end
        load_req = 1'b1; load_bcd = 16'h0000;
        run(1);
        load_req = 1'b0;
        run(4);
        vectors++;
        if (load_ack !== 1'b1 || digit_sel !== 4'hE || segment !== 7'h40) begin
            miscompares++;
            $display("FAIL lz0_d0: ack=%b sel=%h seg=%h want 1/E/40", load_ack, digit_sel, segment);
        end
        for (int d = 1; d < 4; d++) begin
            run(5);
            vectors++;
            if (digit_sel !== ~(4'b0001 << d) || segment !== LZ_SEG) begin
                miscompares++;
                $display("FAIL lz0_d%0d: sel=%h seg=%h want %h/%h", d, digit_sel, segment, ~(4'b0001 << d), LZ_SEG);
            end
        end
    endtask

    task automatic test_back_to_back();
        load_req = 1'b1; load_bcd = 16'h0001;
        run(1);
        vectors++;
        if (load_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: ready=%b want 0", load_ready);
        end
        load_bcd = 16'h0007;
        run(4);
        vectors++;
        if (load_ack !== 1'b1 || frame_done !== 1'b1 || segment !== 7'h79 || load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_boundary: ack=%b fd=%b seg=%h ready=%b want 1/1/79/1",
                     load_ack, frame_done, segment, load_ready);
        end
        run(1);
        load_req = 1'b0;
        vectors++;
        if (load_ready !== 1'b0 || load_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: ready=%b ack=%b want 0/0", load_ready, load_ack);
        end
        run(19);
        vectors++;
        if (load_ack !== 1'b1 || digit_sel !== 4'hE || segment !== 7'h78) begin
            miscompares++;
            $display("FAIL b2b_apply: ack=%b sel=%h seg=%h want 1/E/78", load_ack, digit_sel, segment);
        end
    endtask

    task automatic test_async_reset();
        #3;
        reset_L = 1'b0;
        #1;
        vectors++;
        if (digit_sel !== 4'hF || segment !== 7'h7F || load_ready !== 1'b1 || load_ack !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: sel=%h seg=%h ready=%b ack=%b fd=%b want F/7f/1/0/0",
                     digit_sel, segment, load_ready, load_ack, frame_done);
        end
        run(2);
        vectors++;
        if (digit_sel !== 4'hF || segment !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_held: sel=%h seg=%h want F/7f", digit_sel, segment);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_scan();
        test_mid_frame_load();
        test_nonbcd_backpressure();
        test_enable_drop();
        test_leading_zero();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
